rip_lsu: RTL and testbench
==========================

# rip_lsu

Load/store unit on the requester side of the byte-addressed data memory port. It accepts one load or store per handshake from the pipeline MEM stage and issues word-aligned read/write requests to the memory, stalling on `mem_busy`. It performs sub-word stores by read-modify-write, and it extracts and sign- or zero-extends sub-word loads. It returns one response per accepted request.

## Interface
- `DATA_WIDTH`, default 32: data path width. Only 32 is supported.
- `ADDR_WIDTH`, default 32: byte address width.
- `clk` in 1: clock. All state changes on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: pipeline request valid.
- `req_ready` out 1: unit can accept a request.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I access width/sign encoding.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: store data, right-aligned.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out DATA_WIDTH: extended load result. 0 for stores and errors.
- `resp_err` out 1: request rejected. Valid only with `resp_valid`.
- `mem_we` out 1: memory write request.
- `mem_re` out 1: memory read request.
- `mem_addr` out ADDR_WIDTH: word-aligned address; bits [1:0] are always 0.
- `mem_din` out DATA_WIDTH: write data, full word.
- `mem_dout` in DATA_WIDTH: read data from memory.
- `mem_busy` in 1: memory is stalling the current request.

## Operation
- States: IDLE, RD, RDW, WR, RESP.
- **Accept rule:** a request is accepted when `req_valid && req_ready`. `req_ready` = 1 only in IDLE. On accept, addr, funct3, store flag and wdata are registered.
- **funct3 decode:**
  - 000 = byte, 001 = half, 010 = word, 100 = byte unsigned (load only), 101 = half unsigned (load only).
  - Any other code, or 100/101 with a store, is invalid: go IDLE→RESP with `resp_err` = 1 and no memory access.
- **Transitions from IDLE on accept:**
  - Load → RD.
  - Word store → WR.
  - Byte/half store → RD.
- **RD:** `mem_re` = 1 and `mem_addr` = {addr[ADDR_WIDTH-1:2], 2'b00}, held until an edge with `mem_busy` = 0, then → RDW.
- **RDW:** `mem_re` = 0. On the first edge with `mem_busy` = 0, `mem_dout` is captured.
  - Load → RESP.
  - Sub-word store → WR with the merged word: the selected byte (addr[1:0]) or half (addr[1]) is replaced by the low bits of wdata; all other bytes are kept.
- **WR:** `mem_we` = 1, `mem_addr` aligned, `mem_din` = word (wdata for word stores, merged word otherwise). Held until an edge with `mem_busy` = 0, then → RESP.
- **RESP:** `resp_valid` = 1 for exactly one cycle, then → IDLE.
  - Loads: `resp_rdata` = selected byte/half, shifted to bit 0; sign-extended for 000/001, zero-extended for 100/101. Word loads return the full word.
- `mem_we` and `mem_re` are never asserted together. Both are 0 outside WR/RD.
- Request inputs are ignored outside IDLE.

## Timing
- **Reset values:**
  - `req_ready` = 1.
  - `resp_valid`, `resp_err`, `mem_we`, `mem_re` = 0.
  - `resp_rdata`, `mem_addr`, `mem_din` = 0.
  - State = IDLE.
- Reset asserted mid-operation drops `mem_we`/`mem_re` immediately (asynchronous). The in-flight access is abandoned and no response is produced.
- **Latency with `mem_busy` = 0, counted in cycles from accept edge to `resp_valid` high:**
  - Load: 3.
  - Word store: 2.
  - Sub-word store: 4.
  - Error: 1.
- Each cycle of `mem_busy` = 1 in RD, RDW or WR adds exactly one cycle.
- Back-to-back throughput: `req_ready` returns 1 the cycle after RESP. The minimum spacing between accepts equals latency + 1.

## Configuration
- **`RIP_LSU_MISALIGN_TRAP_EN` defined:**
  - A half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, is an error: IDLE→RESP with `resp_err` = 1 and no memory access.
- **Undefined:**
  - Misaligned low bits are truncated: half uses addr[1], word ignores addr[1:0].
  - No error is raised for misalignment; only invalid funct3 errors.

## Test plan
- Reset, then SW of 0xDEADBEEF to 0x100 with busy = 0 → `mem_we` = 1 in cycle 1 with `mem_addr` = 0x100 and `mem_din` = 0xDEADBEEF; `resp_valid` in cycle 2, `resp_err` = 0.
- Memory word 0x100 holds 0xDEADBEEF:
  - LB 0x103 → `resp_rdata` = 0xFFFFFFDE.
  - LBU 0x103 → 0x000000DE.
  - LH 0x100 → 0xFFFFBEEF.
  - LHU 0x102 → 0x0000DEAD.
- SB of 0x55 to 0x101 over word 0xDEADBEEF → read at 0x100, then `mem_din` = 0xDEAD55EF; `resp_valid` 4 cycles after accept.
- Load with `mem_busy` held 1 for 3 cycles in RD → `mem_re` held for 4 cycles; `resp_valid` 6 cycles after accept.
- Invalid cases:
  - funct3 = 011 load → `resp_valid` and `resp_err` = 1 one cycle after accept; `mem_re`/`mem_we` never asserted.
  - With `RIP_LSU_MISALIGN_TRAP_EN`, LW at 0x102 gives the same error.
  - Without the macro, LW at 0x102 reads 0x100.
- `rstn` pulsed low during WR with busy = 1 → `mem_we` falls without a clock edge; no `resp_valid`; `req_ready` = 1 after release.

Source files
------------

// File: rtl/rip_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : rip_lsu_if
// Brief    : Pipeline request/response and data-memory port bundle for rip_lsu.
// Revision : 1.0 - initial release
// ============================================================================
interface rip_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_busy;

  // Environment side: pipeline MEM stage plus data memory.
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output mem_dout, mem_busy,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_we, mem_re, mem_addr, mem_din
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  mem_dout, mem_busy,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_we, mem_re, mem_addr, mem_din
  );
endinterface
`default_nettype wire

// File: rtl/rip_lsu.sv
`default_nettype none
// ============================================================================
// Module   : rip_lsu
// Brief    : Load/store unit; word-aligned memory access, read-modify-write
//            sub-word stores, extended sub-word loads. Macro
//            RIP_LSU_MISALIGN_TRAP_EN turns misaligned half/word into errors.
// Revision : 1.0 - initial release
// ============================================================================
module rip_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rstn,
  rip_lsu_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic                  r_store;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_f3_ok;
  logic                  w_misalign;
  logic                  w_req_err;
  logic                  w_sx;
  logic                  w_rd_act;
  logic                  w_wr_act;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [ADDR_WIDTH-1:0] w_addr_al;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  always_comb begin
    w_f3_ok = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !bus.req_store;
      default:                w_f3_ok = 1'b0;
    endcase
  end

`ifdef RIP_LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((bus.req_funct3[1:0] == c_SZ_HALF) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == c_SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = !w_f3_ok || w_misalign;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
          end else if (bus.req_store && (bus.req_funct3[1:0] == c_SZ_WORD)) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD:    if (!bus.mem_busy) w_state_nxt = S_RDW;
      S_RDW:   if (!bus.mem_busy) w_state_nxt = r_store ? S_WR : S_RESP;
      S_WR:    if (!bus.mem_busy) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane selection for loads; unsigned codes have funct3[2] set.
  always_comb begin
    w_byte = bus.mem_dout[7:0];
    case (r_addr[1:0])
      2'b00: w_byte = bus.mem_dout[7:0];
      2'b01: w_byte = bus.mem_dout[15:8];
      2'b10: w_byte = bus.mem_dout[23:16];
      2'b11: w_byte = bus.mem_dout[31:24];
    endcase
  end

  assign w_half = r_addr[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
  assign w_sx   = !r_funct3[2];

  always_comb begin
    w_load = bus.mem_dout;
    case (r_funct3[1:0])
      c_SZ_BYTE: w_load = {{(DATA_WIDTH-8){w_sx & w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load = {{(DATA_WIDTH-16){w_sx & w_half[15]}}, w_half};
      default:   w_load = bus.mem_dout;
    endcase
  end

  // Read-modify-write merge: only the addressed lane takes store data.
  always_comb begin
    w_merged = bus.mem_dout;
    case (r_funct3[1:0])
      c_SZ_BYTE: begin
        case (r_addr[1:0])
          2'b00: w_merged[7:0]   = r_word[7:0];
          2'b01: w_merged[15:8]  = r_word[7:0];
          2'b10: w_merged[23:16] = r_word[7:0];
          2'b11: w_merged[31:24] = r_word[7:0];
        endcase
      end
      c_SZ_HALF: begin
        if (r_addr[1]) begin
          w_merged[31:16] = r_word[15:0];
        end else begin
          w_merged[15:0] = r_word[15:0];
        end
      end
      default: w_merged = r_word;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_store  <= 1'b0;
      r_err    <= 1'b0;
      r_word   <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= bus.req_addr;
        r_funct3 <= bus.req_funct3;
        r_store  <= bus.req_store;
        r_err    <= w_req_err;
        r_word   <= bus.req_wdata;
        r_rdata  <= '0;
      end else if ((r_state == S_RDW) && !bus.mem_busy) begin
        if (r_store) begin
          r_word <= w_merged;
        end else begin
          r_rdata <= w_load;
        end
      end
    end
  end

  // Outputs decode straight from state so reset removes requests immediately.
  assign w_rd_act  = (r_state == S_RD);
  assign w_wr_act  = (r_state == S_WR);
  assign w_addr_al = {r_addr[ADDR_WIDTH-1:2], 2'b00};

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.mem_re     = w_rd_act;
  assign bus.mem_we     = w_wr_act;
  assign bus.mem_addr   = (w_rd_act || w_wr_act) ? w_addr_al : '0;
  assign bus.mem_din    = w_wr_act ? r_word : '0;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_err   = (r_state == S_RESP) && r_err;
  assign bus.resp_rdata = ((r_state == S_RESP) && !r_err) ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_rip_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_rip_lsu
// Brief    : Self-checking bench for rip_lsu: directed table, corner sequences
//            and randomized traffic against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rip_lsu;

  logic clk = 1'b0;
  logic rstn;
  logic mem_clr;
  always #5 clk = ~clk;

  rip_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  rip_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  logic [31:0] tmem [0:255];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) tmem[i] <= '0;
    end else begin
      if (bus.mem_re && !bus.mem_busy) bus.mem_dout <= tmem[bus.mem_addr[9:2]];
      if (bus.mem_we && !bus.mem_busy) tmem[bus.mem_addr[9:2]] <= bus.mem_din;
    end
  end

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    int          lat;
  } vec_t;

  localparam int NV = 25;
  vec_t tab [0:NV-1];
  int n_vec;
  int n_miss;
  logic [7:0] ref_b [0:1023];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, bit err, int lat);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd; v.err = err; v.lat = lat;
    return v;
  endfunction

  function automatic int ref_size(logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_err(bit st, logic [2:0] f3, logic [31:0] a);
    bit ok;
    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
`ifdef RIP_LSU_MISALIGN_TRAP_EN
    if (ok && ((int'(a[1:0]) % ref_size(f3)) != 0)) ok = 1'b0;
`endif
    return !ok;
  endfunction

  function automatic int ref_base(logic [2:0] f3, logic [31:0] a);
    int b;
    b = int'(a[9:0]);
    return b - (b % ref_size(f3));
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    int sz;
    int b;
    longint v;
    sz = ref_size(f3);
    b  = ref_base(f3, a);
    v  = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_b[b + i]) << (8 * i);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  task automatic ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    int b;
    b = ref_base(f3, a);
    for (int i = 0; i < ref_size(f3); i++) ref_b[b + i] = 8'(wd >> (8 * i));
  endtask

  function automatic logic [31:0] ref_word(logic [31:0] a);
    int b;
    b = int'(a[9:0]) & ~3;
    return {ref_b[b + 3], ref_b[b + 2], ref_b[b + 1], ref_b[b]};
  endfunction

  // One request end to end; busy is held for the first `lead` in-flight cycles
  // and optionally toggled at random afterwards.
  task automatic apply(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lead, input bit rnd,
                       input bit use_tab, input logic [31:0] t_rd, input bit t_err,
                       input int t_lat, output int lat_o, output int nre_o);
    bit e_err, saw_re, saw_we, busy;
    logic [31:0] e_rd, e_word;
    int e_lat, sz, lat, nbusy, n_re, first_re, first_we, bad;
    sz    = ref_size(f3);
    e_err = ref_err(st, f3, a);
    e_rd  = (st || e_err) ? 32'h0 : ref_load(f3, a);
    e_lat = e_err ? 1 : (!st ? 3 : (sz == 4 ? 2 : 4));
    if (st && !e_err) ref_store(f3, a, wd);
    e_word = ref_word(a);
    if (use_tab) begin
      e_rd = t_rd; e_err = t_err; e_lat = t_lat;
    end
    bad = 0; n_re = 0; nbusy = 0; first_re = 0; first_we = 0; saw_re = 0; saw_we = 0;
    chk("ready_idle", 32'(bus.req_ready), 32'd1);
    if (bus.mem_re || bus.mem_we) bad++;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.mem_busy   = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 100) begin
      if (bus.mem_re && bus.mem_we) bad++;
      if (bus.req_ready !== 1'b0) bad++;
      if (bus.mem_re) begin
        n_re++; saw_re = 1'b1;
        if (first_re == 0) first_re = lat;
      end
      if (bus.mem_we) begin
        saw_we = 1'b1;
        if (first_we == 0) first_we = lat;
        if (bus.mem_din !== e_word) bad++;
      end
      if ((bus.mem_re || bus.mem_we) && bus.mem_addr !== {a[31:2], 2'b00}) bad++;
      busy = (lat <= lead) || (rnd && $urandom_range(0, 3) == 0);
      if (busy) nbusy++;
      bus.mem_busy   = busy;
      bus.req_valid  = 1'($urandom);
      bus.req_store  = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    bus.req_valid = 1'b0;
    bus.mem_busy  = 1'b0;
    chk("resp_timeout", 32'(lat >= 100), 32'd0);
    if (bus.mem_re || bus.mem_we) bad++;
    chk("resp_err", 32'(bus.resp_err), 32'(e_err));
    chk("resp_rdata", bus.resp_rdata, e_rd);
    chk("latency", 32'(lat), 32'(e_lat + nbusy));
    chk("read_access", 32'(saw_re), 32'(!e_err && (!st || sz < 4)));
    chk("write_access", 32'(saw_we), 32'(!e_err && st));
    chk("protocol", 32'(bad), 32'd0);
    if (lead == 0 && !rnd) begin
      if (saw_re) chk("first_re_cycle", 32'(first_re), 32'd1);
      if (saw_we) chk("first_we_cycle", 32'(first_we), 32'(sz == 4 ? 1 : 3));
    end
    @(posedge clk); #1;
    chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
    lat_o = lat;
    nre_o = n_re;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, nre;
    logic [31:0] a;
    n_vec = 0;
    n_miss = 0;
    for (int i = 0; i < 1024; i++) ref_b[i] = '0;
    mem_clr        = 1'b1;
    rstn           = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_busy   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_flags", {28'd0, bus.resp_valid, bus.resp_err, bus.mem_we, bus.mem_re}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    rstn    = 1'b1;
    mem_clr = 1'b0;
    @(posedge clk); #1;

    tab[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2);
    tab[1]  = mk(0, 3'b000, 32'h103, 32'h0, 32'hFFFFFFDE, 0, 3);
    tab[2]  = mk(0, 3'b100, 32'h103, 32'h0, 32'h000000DE, 0, 3);
    tab[3]  = mk(0, 3'b001, 32'h100, 32'h0, 32'hFFFFBEEF, 0, 3);
    tab[4]  = mk(0, 3'b101, 32'h102, 32'h0, 32'h0000DEAD, 0, 3);
    tab[5]  = mk(1, 3'b000, 32'h101, 32'hABCDEF55, 32'h0, 0, 4);
    tab[6]  = mk(0, 3'b010, 32'h100, 32'h0, 32'hDEAD55EF, 0, 3);
    tab[7]  = mk(0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1);
    tab[8]  = mk(1, 3'b100, 32'h100, 32'hFF, 32'h0, 1, 1);
    tab[9]  = mk(1, 3'b101, 32'h100, 32'hFFFF, 32'h0, 1, 1);
    tab[10] = mk(0, 3'b110, 32'h100, 32'h0, 32'h0, 1, 1);
    tab[11] = mk(1, 3'b111, 32'h100, 32'h1, 32'h0, 1, 1);
    tab[13] = mk(1, 3'b001, 32'h102, 32'h1234A5A5, 32'h0, 0, 4);
    tab[14] = mk(0, 3'b010, 32'h100, 32'h0, 32'hA5A555EF, 0, 3);
    tab[16] = mk(0, 3'b100, 32'h100, 32'h0, 32'h000000EF, 0, 3);
    tab[17] = mk(0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFEF, 0, 3);
    tab[18] = mk(1, 3'b000, 32'h103, 32'h00000080, 32'h0, 0, 4);
    tab[19] = mk(0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 0, 3);
`ifdef RIP_LSU_MISALIGN_TRAP_EN
    tab[12] = mk(0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1);
    tab[15] = mk(0, 3'b001, 32'h103, 32'h0, 32'h0, 1, 1);
    tab[20] = mk(1, 3'b010, 32'h105, 32'h11223344, 32'h0, 1, 1);
    tab[21] = mk(0, 3'b010, 32'h104, 32'h0, 32'h0, 0, 3);
    tab[22] = mk(1, 3'b001, 32'h101, 32'h00007777, 32'h0, 1, 1);
    tab[23] = mk(0, 3'b010, 32'h100, 32'h0, 32'h80A555EF, 0, 3);
    tab[24] = mk(0, 3'b101, 32'h100, 32'h0, 32'h000055EF, 0, 3);
`else
    tab[12] = mk(0, 3'b010, 32'h102, 32'h0, 32'hDEAD55EF, 0, 3);
    tab[15] = mk(0, 3'b001, 32'h103, 32'h0, 32'hFFFFA5A5, 0, 3);
    tab[20] = mk(1, 3'b010, 32'h105, 32'h11223344, 32'h0, 0, 2);
    tab[21] = mk(0, 3'b010, 32'h104, 32'h0, 32'h11223344, 0, 3);
    tab[22] = mk(1, 3'b001, 32'h101, 32'h00007777, 32'h0, 0, 4);
    tab[23] = mk(0, 3'b010, 32'h100, 32'h0, 32'h80A57777, 0, 3);
    tab[24] = mk(0, 3'b101, 32'h100, 32'h0, 32'h00007777, 0, 3);
`endif
    for (int i = 0; i < NV; i++) begin
      apply(tab[i].st, tab[i].f3, tab[i].addr, tab[i].wd, 0, 0, 1,
            tab[i].rd, tab[i].err, tab[i].lat, lat, nre);
    end

    // Busy for three cycles in RD stretches the read and the response.
    apply(0, 3'b010, 32'h100, 32'h0, 3, 0, 0, 32'h0, 0, 0, lat, nre);
    chk("busy_rd_latency", 32'(lat), 32'd6);
    chk("busy_rd_re_cycles", 32'(nre), 32'd4);
    apply(1, 3'b010, 32'h108, 32'hCAFEF00D, 2, 0, 0, 32'h0, 0, 0, lat, nre);
    chk("busy_wr_latency", 32'(lat), 32'd4);
    apply(0, 3'b010, 32'h108, 32'h0, 0, 1, 0, 32'h0, 0, 0, lat, nre);

    // Reset pulsed mid-write must drop mem_we without waiting for a clock edge.
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h200;
    bus.req_wdata  = 32'h12345678;
    bus.mem_busy   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_mid_we_before", 32'(bus.mem_we), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_we_async", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
    chk("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_hold", {30'd0, bus.resp_valid, bus.mem_we}, 32'd0);
    rstn         = 1'b1;
    bus.mem_busy = 1'b0;
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_mid_after", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    apply(0, 3'b010, 32'h200, 32'h0, 0, 0, 0, 32'h0, 0, 0, lat, nre);

    for (int n = 0; n < 300; n++) begin
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 127));
      apply(1'($urandom), 3'($urandom), a, $urandom, 0, 1, 0, 32'h0, 0, 0, lat, nre);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
